intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Interrupt controller that responds to the PC control unit's `intr` input.
- Synchronises an external request and latches it as pending.
- Raises `intr` for exactly one cycle, aligned with an instruction boundary (`instr_done`).
- Pushes the return address and flags to the stack port, masks nesting until RTI, then restores the flags.

Parameters:
- PC_WIDTH, 8, width of PC / return address.
- SYNC_STAGES, 2, flip-flop stages on `irq_in` (min 2).
- EDGE_TRIG, 1, 1 = rising-edge triggered request, 0 = level triggered.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- irq_in  in  1  asynchronous external interrupt request
- ie  in  1  global interrupt enable; 0 blocks acceptance (pending is kept)
- instr_done  in  1  instruction-boundary strobe from PC control unit
- opcode  in  4  opcode of the completing instruction
- brx  in  2  sub-op field
- pc_value  in  PC_WIDTH  current PC
- flags_in  in  4  {V,C,N,Z}
- intr  out  1  interrupt strobe to PC control unit
- push_req  out  1  one-cycle stack push request
- push_data  out  PC_WIDTH  return address to push
- flags_restore  out  1  one-cycle strobe: load flags from `saved_flags`
- saved_flags  out  4  flags captured at acceptance
- pending  out  1  request latched, not yet accepted
- in_isr  out  1  handler active, nesting masked

Behaviour:
- Reset: all state cleared, including the sync chain and previous sample. FSM enters IDLE.
  - Outputs: `intr`, `push_req`, `flags_restore`, `pending`, `in_isr` = 0; `push_data` = 0; `saved_flags` = 0.
  - Reset mid-handler discards pending, saved and in-ISR state.
- Sync and pending:
  - `irq_s` = `irq_in` delayed SYNC_STAGES clocks.
  - EDGE_TRIG=1: `pending` sets on `irq_s` & !previous `irq_s`.
  - EDGE_TRIG=0: `pending` sets whenever `irq_s` = 1.
  - `pending` clears only on the accept cycle; a new edge arriving on the accept cycle re-sets it.
  - Requests during IN_ISR stay pending.
- "cf" = (opcode==9) | (opcode==10) | (opcode==11). "rti" = (opcode==11) & (brx==3).
- States:
  - IDLE: if `pending` & `ie`, go to ARMED.
  - ARMED:
    - `intr` = `instr_done` & !cf (combinational, this state only).
    - When `intr`=1 (accept cycle):
      - clear `pending`;
      - capture `push_data` <= `pc_value`+1 mod 2^PC_WIDTH;
      - capture `saved_flags` <= `flags_in`;
      - go to SAVE.
    - On a cf boundary, stay ARMED to the next `instr_done` (so a branch/jump/RET is not overridden).
    - If `ie` drops before accept, return to IDLE; `pending` is kept.
  - SAVE: `push_req`=1 for exactly one cycle; `intr`=0 (PC control unit leaves DONE); go to ISR.
  - ISR: `in_isr`=1. On `instr_done` & rti, pulse `flags_restore` for that cycle and go to IDLE. A plain RET (brx==2) does not exit ISR.
- Latency: `irq_in` edge → `pending` = SYNC_STAGES+1 clocks. `pending` → ARMED = 1 clock. Accept at the first non-cf `instr_done` while ARMED. `push_req` on the following cycle.
- `intr` never high for 2 consecutive cycles and never outside ARMED.
- `in_isr` is high only in ISR.
- `push_data` and `saved_flags` hold their values until the next accept.
- Simultaneous events:
  - rti completing while `pending`: exit to IDLE, then re-arm the next cycle (back-to-back interrupts allowed).
  - `ie` and `instr_done` rising on the same cycle in IDLE: no accept that cycle (ARMED not yet reached).

Test Plan:
- Basic: reset, `ie`=1; pulse `irq_in` at cycle 10; `instr_done` with opcode=0 at cycle 16, `pc_value`=0x3F, `flags_in`=4'b0101.
  - `pending`=1 at cycle 13.
  - `intr`=1 only at cycle 16.
  - `push_req`=1 at cycle 17 with `push_data`=0x40; `saved_flags`=0101; `in_isr`=1 from cycle 18.
- Control-flow deferral: while ARMED, `instr_done` with opcode=9 → `intr`=0. Next `instr_done` with opcode=1 → `intr`=1.
- Nesting mask and exit:
  - In ISR, a second `irq_in` edge → `pending`=1, no `intr`.
  - Opcode=11/brx=2 `instr_done` → stays ISR.
  - Opcode=11/brx=3 → `flags_restore` pulse; re-armed, and `intr` at the next non-cf `instr_done`.
- Wrap: `pc_value`=0xFF at accept → `push_data`=0x00.
- Mask: `ie`=0 with `pending`=1 for 20 cycles of `instr_done` → no `intr`. `ie`=1 → accept at the first non-cf boundary after re-arm.
- Reset mid-ISR: assert `reset` in ISR with `pending`=1 → next cycle all outputs 0, state IDLE; EDGE_TRIG=0 with `irq_in` held high re-pends after SYNC_STAGES+1 clocks.

Source files
------------

// File: rtl/intr_ctrl_if.sv
// Bus between the PC control unit and the interrupt controller.
//   master : PC control unit side (drives instruction-boundary info,
//            receives intr / stack push / flag restore)
//   slave  : interrupt controller side
// Signals:
//   instr_done    instruction-boundary strobe
//   opcode/brx    opcode and sub-op of the completing instruction
//   pc_value      current PC
//   flags_in      {V,C,N,Z}
//   intr          one-cycle interrupt strobe
//   push_req      one-cycle stack push request
//   push_data     return address to push
//   flags_restore one-cycle strobe: load flags from saved_flags
//   saved_flags   flags captured at acceptance
interface intr_ctrl_if #(
  parameter int unsigned PC_WIDTH = 8
);
  logic                instr_done;
  logic [3:0]          opcode;
  logic [1:0]          brx;
  logic [PC_WIDTH-1:0] pc_value;
  logic [3:0]          flags_in;
  logic                intr;
  logic                push_req;
  logic [PC_WIDTH-1:0] push_data;
  logic                flags_restore;
  logic [3:0]          saved_flags;

  modport master (
    output instr_done, opcode, brx, pc_value, flags_in,
    input  intr, push_req, push_data, flags_restore, saved_flags
  );

  modport slave (
    input  instr_done, opcode, brx, pc_value, flags_in,
    output intr, push_req, push_data, flags_restore, saved_flags
  );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller for the PC control unit.
// Synchronises an asynchronous request, latches it as pending, and raises
// intr for one cycle on a non-control-flow instruction boundary. After
// acceptance it requests a push of the return address, masks nesting
// until RTI, then strobes a flag restore.
// Ports:
//   clk, reset  clock; synchronous active-high reset
//   irq_in      asynchronous external interrupt request
//   ie          global interrupt enable (0 blocks acceptance, keeps pending)
//   bus         intr_ctrl_if.slave (PC control unit / stack handshake)
//   pending     request latched, not yet accepted
//   in_isr      handler active, nesting masked
module intr_ctrl #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TRIG   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_in,
  input  logic        ie,
  intr_ctrl_if.slave  bus,
  output logic        pending,
  output logic        in_isr
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SAVE,
    ISR
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    irq_prev;
  logic                    push_req_q;
  logic [PC_WIDTH-1:0]     push_data_q;
  logic [3:0]              saved_flags_q;

  logic irq_s;
  logic set_req;
  logic is_cf;
  logic is_rti;
  logic accept;
  logic isr_exit;

  assign irq_s   = sync_q[SYNC_STAGES-1];
  assign set_req = (EDGE_TRIG != 0) ? (irq_s & ~irq_prev) : irq_s;

  // Branch, jump and RET boundaries must not be overridden by an interrupt.
  assign is_cf  = (bus.opcode == 4'd9) | (bus.opcode == 4'd10) | (bus.opcode == 4'd11);
  assign is_rti = (bus.opcode == 4'd11) & (bus.brx == 2'd3);

  assign accept   = (state == ARMED) & bus.instr_done & ~is_cf;
  assign isr_exit = (state == ISR) & bus.instr_done & is_rti;

  assign bus.intr          = accept;
  assign bus.flags_restore = isr_exit;
  assign bus.push_req      = push_req_q;
  assign bus.push_data     = push_data_q;
  assign bus.saved_flags   = saved_flags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      sync_q        <= '0;
      irq_prev      <= 1'b0;
      pending       <= 1'b0;
      push_req_q    <= 1'b0;
      in_isr        <= 1'b0;
      push_data_q   <= '0;
      saved_flags_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], irq_in};
      irq_prev <= irq_s;
      // A fresh request landing on the accept cycle survives the clear.
      pending    <= (pending & ~accept) | set_req;
      push_req_q <= accept;
      if (accept) begin
        push_data_q   <= bus.pc_value + PC_WIDTH'(1);
        saved_flags_q <= bus.flags_in;
      end
      case (state)
        IDLE: begin
          if (pending & ie) state <= ARMED;
        end
        ARMED: begin
          if (accept)   state <= SAVE;
          else if (!ie) state <= IDLE;
        end
        SAVE: begin
          state  <= ISR;
          in_isr <= 1'b1;
        end
        ISR: begin
          if (isr_exit) begin
            state  <= IDLE;
            in_isr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;
  localparam int PCW  = 8;
  localparam int SYNC = 2;
  localparam int OW   = 5 + PCW + 4;
  localparam int NROW = 39;

  localparam int PH_IDLE  = 0;
  localparam int PH_ARMED = 1;
  localparam int PH_SAVE  = 2;
  localparam int PH_ISR   = 3;

  logic           clk = 1'b0;
  logic           reset, irq_in, ie, done;
  logic [3:0]     op, fl;
  logic [1:0]     brx;
  logic [PCW-1:0] pc;
  logic           pend0, isr0, pend1, isr1;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  intr_ctrl_if #(.PC_WIDTH(PCW)) bus0 ();
  intr_ctrl_if #(.PC_WIDTH(PCW)) bus1 ();

  assign bus0.instr_done = done;
  assign bus0.opcode     = op;
  assign bus0.brx        = brx;
  assign bus0.pc_value   = pc;
  assign bus0.flags_in   = fl;
  assign bus1.instr_done = done;
  assign bus1.opcode     = op;
  assign bus1.brx        = brx;
  assign bus1.pc_value   = pc;
  assign bus1.flags_in   = fl;

  intr_ctrl #(.PC_WIDTH(PCW), .SYNC_STAGES(SYNC), .EDGE_TRIG(1)) dut_edge (
    .clk(clk), .reset(reset), .irq_in(irq_in), .ie(ie),
    .bus(bus0), .pending(pend0), .in_isr(isr0)
  );

  intr_ctrl #(.PC_WIDTH(PCW), .SYNC_STAGES(SYNC), .EDGE_TRIG(0)) dut_level (
    .clk(clk), .reset(reset), .irq_in(irq_in), .ie(ie),
    .bus(bus1), .pending(pend1), .in_isr(isr1)
  );

  // Observed output bundle: {intr, push_req, flags_restore, pending, in_isr, push_data, saved_flags}
  wire [OW-1:0] obs0 = {bus0.intr, bus0.push_req, bus0.flags_restore, pend0, isr0,
                        bus0.push_data, bus0.saved_flags};
  wire [OW-1:0] obs1 = {bus1.intr, bus1.push_req, bus1.flags_restore, pend1, isr1,
                        bus1.push_data, bus1.saved_flags};

  // ---------------- reference model ----------------
  bit             irq_hist[$];   // irq_in samples since last reset, oldest first
  int             m_phase[2];
  bit             m_pend[2];
  logic [PCW-1:0] m_pdata[2];
  logic [3:0]     m_sf[2];

  function automatic bit delayed_irq(int d);
    if (irq_hist.size() >= d) return irq_hist[irq_hist.size() - d];
    return 1'b0;
  endfunction

  function automatic bit is_cf(logic [3:0] o);
    return (o == 4'd9) || (o == 4'd10) || (o == 4'd11);
  endfunction

  function automatic logic [OW-1:0] expect_out(int k);
    bit e_intr, e_push, e_rest;
    e_intr = (m_phase[k] == PH_ARMED) && done && !is_cf(op);
    e_push = (m_phase[k] == PH_SAVE);
    e_rest = (m_phase[k] == PH_ISR) && done && (op == 4'd11) && (brx == 2'd3);
    return {e_intr, e_push, e_rest, m_pend[k], (m_phase[k] == PH_ISR), m_pdata[k], m_sf[k]};
  endfunction

  task automatic model_step();
    bit s_now, s_old, req, acc;
    if (reset) begin
      irq_hist.delete();
      for (int k = 0; k < 2; k++) begin
        m_phase[k] = PH_IDLE;
        m_pend[k]  = 1'b0;
        m_pdata[k] = '0;
        m_sf[k]    = '0;
      end
      return;
    end
    s_now = delayed_irq(SYNC);
    s_old = delayed_irq(SYNC + 1);
    for (int k = 0; k < 2; k++) begin
      req = (k == 0) ? (s_now && !s_old) : s_now;
      acc = (m_phase[k] == PH_ARMED) && done && !is_cf(op);
      case (m_phase[k])
        PH_IDLE:  if (m_pend[k] && ie) m_phase[k] = PH_ARMED;
        PH_ARMED: if (acc) m_phase[k] = PH_SAVE; else if (!ie) m_phase[k] = PH_IDLE;
        PH_SAVE:  m_phase[k] = PH_ISR;
        default:  if (done && op == 4'd11 && brx == 2'd3) m_phase[k] = PH_IDLE;
      endcase
      m_pend[k] = (m_pend[k] && !acc) || req;
      if (acc) begin
        m_pdata[k] = pc + 1;
        m_sf[k]    = fl;
      end
    end
    irq_hist.push_back(irq_in);
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(string name, logic [OW-1:0] got, logic [OW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic check1(string name, logic got, logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask

  // Sample at the falling edge and compare both DUTs against the model.
  task automatic settle(bit chk);
    @(negedge clk);
    if (chk) begin
      check("model_edge", obs0, expect_out(0));
      check("model_level", obs1, expect_out(1));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    done = 1'b0; op = 4'd0; brx = 2'd0; pc = '0; fl = 4'd0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic           irq, ie, done;
    logic [3:0]     op;
    logic [1:0]     brx;
    logic [PCW-1:0] pc;
    logic [3:0]     fl;
    logic           x_intr, x_push, x_rest, x_pend, x_isr;
    logic [PCW-1:0] x_pdata;
    logic [3:0]     x_sf;
  } vec_t;

  vec_t tbl[NROW];

  initial begin
    reset = 1'b1; irq_in = 1'b0; ie = 1'b0;
    idle_inputs();

    // Row r is cycle r after reset release.
    for (int r = 0; r < NROW; r++) begin
      tbl[r] = '{default: '0};
      tbl[r].ie      = 1'b1;
      tbl[r].x_pend  = ((r >= 13) && (r <= 16)) || ((r >= 23) && (r <= 32));
      tbl[r].x_isr   = ((r >= 18) && (r <= 27)) || ((r >= 34) && (r <= 35));
      tbl[r].x_intr  = (r == 16) || (r == 32);
      tbl[r].x_push  = (r == 17) || (r == 33);
      tbl[r].x_rest  = (r == 27) || (r == 35);
      tbl[r].x_pdata = (r >= 33) ? 8'h00 : ((r >= 17) ? 8'h40 : 8'h00);
      tbl[r].x_sf    = (r >= 33) ? 4'b1010 : ((r >= 17) ? 4'b0101 : 4'b0000);
    end
    tbl[10].irq = 1'b1;
    tbl[16].done = 1'b1; tbl[16].op = 4'd0;  tbl[16].pc = 8'h3F; tbl[16].fl = 4'b0101;
    tbl[20].irq = 1'b1;
    tbl[25].done = 1'b1; tbl[25].op = 4'd11; tbl[25].brx = 2'd2;
    tbl[27].done = 1'b1; tbl[27].op = 4'd11; tbl[27].brx = 2'd3;
    tbl[30].done = 1'b1; tbl[30].op = 4'd9;
    tbl[31].done = 1'b1; tbl[31].op = 4'd10;
    tbl[32].done = 1'b1; tbl[32].op = 4'd1;  tbl[32].pc = 8'hFF; tbl[32].fl = 4'b1010;
    tbl[35].done = 1'b1; tbl[35].op = 4'd11; tbl[35].brx = 2'd3;

    #1;
    settle(0); advance();
    settle(0); advance();
    reset = 1'b0;

    for (int r = 0; r < NROW; r++) begin
      irq_in = tbl[r].irq; ie = tbl[r].ie; done = tbl[r].done;
      op = tbl[r].op; brx = tbl[r].brx; pc = tbl[r].pc; fl = tbl[r].fl;
      settle(1);
      check("table", obs0, {tbl[r].x_intr, tbl[r].x_push, tbl[r].x_rest, tbl[r].x_pend,
                            tbl[r].x_isr, tbl[r].x_pdata, tbl[r].x_sf});
      advance();
    end

    // ---------------- mask with ie=0 ----------------
    idle_inputs();
    ie = 1'b0; irq_in = 1'b1;
    settle(1); advance();
    irq_in = 1'b0;
    for (int i = 0; i < 5; i++) begin settle(1); advance(); end
    check1("mask_pending", pend0, 1'b1);
    done = 1'b1; op = 4'd0;
    for (int i = 0; i < 20; i++) begin
      settle(1);
      check1("mask_no_intr", bus0.intr | bus1.intr, 1'b0);
      advance();
    end
    ie = 1'b1;
    settle(1);
    check1("ie_rise_no_accept", bus0.intr, 1'b0);
    advance();
    settle(1);
    check1("accept_after_rearm", bus0.intr, 1'b1);
    advance();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin settle(1); advance(); end
    done = 1'b1; op = 4'd11; brx = 2'd3;
    settle(1); advance();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin settle(1); advance(); end

    // ---------------- reset mid-ISR, level request held high ----------------
    irq_in = 1'b1; ie = 1'b1;
    for (int i = 0; i < 5; i++) begin settle(1); advance(); end
    done = 1'b1; op = 4'd0; pc = 8'h12; fl = 4'b0011;
    settle(1); advance();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin settle(1); advance(); end
    check1("level_in_isr", isr1, 1'b1);
    check1("level_pending_in_isr", pend1, 1'b1);
    reset = 1'b1;
    settle(1); advance();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle(1);
      if (i == 0) begin
        check("reset_clear_edge", obs0, '0);
        check("reset_clear_level", obs1, '0);
      end
      check1("level_repend", pend1, (i == SYNC + 1));
      advance();
    end

    // ---------------- randomized run ----------------
    irq_in = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(299) == 0);
      if ($urandom_range(7) == 0) irq_in = ~irq_in;
      ie     = ($urandom_range(9) != 0);
      done   = $urandom_range(1);
      op     = ($urandom_range(2) == 0) ? 4'(9 + $urandom_range(2)) : 4'($urandom_range(15));
      brx    = 2'($urandom_range(3));
      pc     = 8'($urandom_range(255));
      fl     = 4'($urandom_range(15));
      settle(1);
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
